// File: rtl/pingpong_coef_ram.sv
// Double-banked coefficient RAM: producer writes one bank while the consumer reads the other.
// Optional macro PINGPONG_COEF_RAM_RDREG_EN registers rd_data (1-cycle read latency).
module pingpong_coef_ram #(
    parameter int unsigned WIDTH          = 13,
    parameter int unsigned ADDR_BITS      = 11,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    input  logic                 swap,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 clear_done,
    output logic                 bank_sel
);

    localparam int unsigned          DEPTH    = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] CNT_LAST = ADDR_BITS'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_WR  = 2'd1,
        CLR_ALL = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
    logic                   bank_sel_q, bank_sel_d;
    logic                   swap_pend_q, swap_pend_d;
    logic                   init_q, init_d;
    logic                   busy_q;
    logic                   done_q;

    logic                   we_a_c;
    logic                   we_b_c;
    logic [ADDR_BITS-1:0]   waddr_c;
    logic [WIDTH-1:0]       wdata_c;
    logic [WIDTH-1:0]       rd_mem_c;

    logic [WIDTH-1:0]       mem_a [DEPTH];
    logic [WIDTH-1:0]       mem_b [DEPTH];

    // init_q holds off the power-up sweep for one cycle so busy stays low in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bank_sel_q  <= 1'b0;
            swap_pend_q <= 1'b0;
            init_q      <= CLEAR_ON_RESET;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bank_sel_q  <= bank_sel_d;
            swap_pend_q <= swap_pend_d;
            init_q      <= init_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bank_sel_d  = bank_sel_q;
        swap_pend_d = swap_pend_q;
        init_d      = init_q;
        we_a_c      = 1'b0;
        we_b_c      = 1'b0;
        waddr_c     = wr_addr;
        wdata_c     = wr_data;

        case (state_q)
            IDLE: begin
                if (init_q) begin
                    init_d      = 1'b0;
                    cnt_d       = '0;
                    state_d     = CLR_ALL;
                    swap_pend_d = swap_pend_q | swap;
                end else begin
                    if (swap) begin
                        bank_sel_d = ~bank_sel_q;
                    end
                    // clear wins over a coincident write
                    if (clear_req) begin
                        cnt_d   = '0;
                        state_d = CLR_WR;
                    end else if (wr_en) begin
                        we_a_c = ~bank_sel_q;
                        we_b_c = bank_sel_q;
                    end
                end
            end
            CLR_WR, CLR_ALL: begin
                waddr_c     = cnt_q;
                wdata_c     = '0;
                we_a_c      = (state_q == CLR_ALL) | ~bank_sel_q;
                we_b_c      = (state_q == CLR_ALL) | bank_sel_q;
                swap_pend_d = swap_pend_q | swap;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_BITS'(1);
                end
            end
            DONE: begin
                cnt_d       = '0;
                state_d     = IDLE;
                swap_pend_d = 1'b0;
                if (swap_pend_q | swap) begin
                    bank_sel_d = ~bank_sel_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (we_a_c) begin
            mem_a[waddr_c] <= wdata_c;
        end
        if (we_b_c) begin
            mem_b[waddr_c] <= wdata_c;
        end
    end

    assign rd_mem_c = bank_sel_q ? mem_a[rd_addr] : mem_b[rd_addr];

`ifdef PINGPONG_COEF_RAM_RDREG_EN
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_mem_c;
        end
    end

    assign rd_data = rd_q;
`else
    assign rd_data = rd_mem_c;
`endif

    assign busy       = busy_q;
    assign clear_done = done_q;
    assign bank_sel   = bank_sel_q;

endmodule

// File: tb/tb_pingpong_coef_ram.sv
// Scoreboard bench for pingpong_coef_ram: stimulus queues expectations, a negedge monitor checks them.
module tb_pingpong_coef_ram;

    localparam int unsigned W  = 13;
    localparam int unsigned AW = 11;
`ifdef PINGPONG_COEF_RAM_RDREG_EN
    localparam bit RDREG = 1'b1;
`else
    localparam bit RDREG = 1'b0;
`endif

    localparam int SEL_RD   = 0;
    localparam int SEL_BANK = 1;
    localparam int SEL_BUSY = 2;
    localparam int SEL_BLEN = 3;
    localparam int SEL_DCNT = 4;
    localparam int SEL_DONE = 5;
    localparam int SEL_TOUT = 6;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          swap;
    logic          clear_req;
    logic          busy;
    logic          clear_done;
    logic          bank_sel;

    exp_t exp_q[$];
    logic obs_req   = 1'b0;
    int   obs_sel   = 0;
    logic obs_rd_d1 = 1'b0;
    logic cnt_clr   = 1'b0;
    logic timed_out = 1'b0;
    int   busy_len  = 0;
    int   done_cnt  = 0;
    int   n_vec     = 0;
    int   n_fail    = 0;

    pingpong_coef_ram #(
        .WIDTH          (W),
        .ADDR_BITS      (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .swap       (swap),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done),
        .bank_sel   (bank_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) obs_rd_d1 <= obs_req && (obs_sel == SEL_RD);

    task automatic check();
        exp_t        e;
        logic [31:0] act;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: got no expectation, required one");
            return;
        end
        e = exp_q.pop_front();
        case (e.sel)
            SEL_RD:   act = 32'(rd_data);
            SEL_BANK: act = 32'(bank_sel);
            SEL_BUSY: act = 32'(busy);
            SEL_BLEN: act = 32'(busy_len);
            SEL_DCNT: act = 32'(done_cnt);
            SEL_DONE: act = 32'(clear_done);
            default:  act = 32'(timed_out);
        endcase
        if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", e.name, act, e.exp);
        end
    endtask

    // Monitor: counts busy cycles / done pulses and pops the scoreboard
    always @(negedge clk) begin
        if (cnt_clr) begin
            busy_len = 0;
            done_cnt = 0;
        end else begin
            if (busy === 1'b1) busy_len++;
            if (clear_done === 1'b1) done_cnt++;
        end
        if (obs_req && !(RDREG && obs_sel == SEL_RD)) check();
        if (RDREG && obs_rd_d1) check();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic observe(input int sel, input logic [31:0] exp, input string name);
        exp_q.push_back('{sel, exp, name});
        obs_sel = sel;
        obs_req = 1'b1;
        tick();
        obs_req = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [AW-1:0] addr, input logic [W-1:0] exp, input string name);
        rd_addr = addr;
        observe(SEL_RD, 32'(exp), name);
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [W-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic wait_idle();
        int i = 0;
        while (i < 3000 && (busy || i < 2)) begin
            tick();
            i++;
        end
        if (busy) timed_out = 1'b1;
        observe(SEL_TOUT, 32'd0, "sweep_timeout");
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        swap      = 1'b0;
        clear_req = 1'b0;
        tick();
        observe(SEL_BUSY, 32'd0, "reset_busy");
        observe(SEL_BANK, 32'd0, "reset_bank_sel");
        observe(SEL_DONE, 32'd0, "reset_clear_done");

        // Power-up clear of both banks
        rst_n   = 1'b1;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        wait_idle();
        observe(SEL_BLEN, 32'd2049, "autoclr_busy_cycles");
        observe(SEL_DCNT, 32'd1, "autoclr_done_pulses");
        rd(11'd0,    13'h0, "autoclr_b_0");
        rd(11'd1023, 13'h0, "autoclr_b_1023");
        rd(11'd2047, 13'h0, "autoclr_b_2047");
        do_swap();
        observe(SEL_BANK, 32'd1, "swap_to_1");
        rd(11'd0,    13'h0, "autoclr_a_0");
        rd(11'd1023, 13'h0, "autoclr_a_1023");
        rd(11'd2047, 13'h0, "autoclr_a_2047");

        // Write bank A, swap, read it back; the write coinciding with swap hits A too
        do_swap();
        observe(SEL_BANK, 32'd0, "swap_to_0");
        wr(11'd5,    13'h11EE);
        wr(11'd2047, 13'h0001);
        wr_en   = 1'b1;
        wr_addr = 11'd9;
        wr_data = 13'h0333;
        swap    = 1'b1;
        tick();
        wr_en = 1'b0;
        swap  = 1'b0;
        observe(SEL_BANK, 32'd1, "swap_with_write");
        rd(11'd5,    13'h11EE, "rd_a_5");
        rd(11'd2047, 13'h0001, "rd_a_2047");
        rd(11'd9,    13'h0333, "rd_a_9_swap_cycle_write");

        // Clear beats a coincident write; read bank untouched by CLR_WR
        clr_cnt();
        wr_en     = 1'b1;
        wr_addr   = 11'd7;
        wr_data   = 13'h0ABC;
        clear_req = 1'b1;
        tick();
        wr_en     = 1'b0;
        clear_req = 1'b0;
        rd(11'd5, 13'h11EE, "rd_during_clr_wr");
        wait_idle();
        observe(SEL_BLEN, 32'd2049, "clr_wr_busy_cycles");
        observe(SEL_DCNT, 32'd1, "clr_wr_done_pulses");
        do_swap();
        observe(SEL_BANK, 32'd0, "swap_after_clear");
        rd(11'd7, 13'h0, "dropped_write_7");

        // Deferred swap, write and clear_req while busy
        clr_cnt();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        do_swap();
        observe(SEL_BANK, 32'd0, "swap_deferred");
        wr(11'd3, 13'h1234);
        do_swap();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        observe(SEL_BUSY, 32'd1, "busy_mid_sweep");
        wait_idle();
        observe(SEL_BLEN, 32'd2049, "ignored_clear_busy_cycles");
        observe(SEL_DCNT, 32'd1, "ignored_clear_done_pulses");
        observe(SEL_BANK, 32'd1, "single_toggle_after_done");
        rd(11'd3, 13'h0, "write_while_busy_3");
        rd(11'd5, 13'h0, "cleared_a_5");

        // Reset in the middle of a sweep, then a full CLR_ALL
        do_swap();
        wr(11'd9, 13'h0555);
        do_swap();
        rd(11'd9, 13'h0555, "rd_a_9_before_reset");
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 500; k++) tick();
        rst_n = 1'b0;
        observe(SEL_BUSY, 32'd0, "async_reset_busy");
        observe(SEL_BANK, 32'd0, "async_reset_bank_sel");
        observe(SEL_DONE, 32'd0, "async_reset_clear_done");
        rst_n   = 1'b1;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        wait_idle();
        observe(SEL_BLEN, 32'd2049, "restart_busy_cycles");
        observe(SEL_DCNT, 32'd1, "restart_done_pulses");
        do_swap();
        rd(11'd9,    13'h0, "clr_all_a_9");
        rd(11'd2047, 13'h0, "clr_all_a_2047");

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pingpong_coef_ram.md
Name: pingpong_coef_ram

Overview:
- Parametrised successor to the single-bank polynomial scratch RAM.
- Holds two banks of distributed-RAM coefficient storage, with the default sized for 13-bit mod-q coefficients over 2048 addresses.
- One bank is written by the producer (e.g. the division loop) while the other is read by the consumer; a swap command exchanges their roles.
- An internal clear engine zeroes the write bank, or both banks after reset, so stale coefficients never leak between polynomial operations.

Parameters:
- WIDTH, 13, coefficient width in bits.
- ADDR_BITS, 11, address width; each bank has DEPTH = 2**ADDR_BITS entries.
- CLEAR_ON_RESET, 1, when 1, both banks are auto-cleared after reset release; when 0, the FSM starts in IDLE.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe into the current write bank.
- wr_addr  input  ADDR_BITS  write address.
- wr_data  input  WIDTH  write data.
- rd_addr  input  ADDR_BITS  read address into the current read bank.
- rd_data  output  WIDTH  read data.
- swap  input  1  single-cycle request to exchange the bank roles.
- clear_req  input  1  single-cycle request to zero the write bank.
- busy  output  1  high while the clear engine is running.
- clear_done  output  1  one-cycle pulse when a clear sweep finishes.
- bank_sel  output  1  0: write bank A, read bank B; 1: write bank B, read bank A.

Behaviour:
- Reset (async assert, sync release):
  - bank_sel=0, busy=0, clear_done=0, clear counter=0, swap_pending=0.
  - rd_data register=0 when the read register is compiled in.
  - Memory contents are not reset.
  - First state after release is CLR_ALL if CLEAR_ON_RESET=1, else IDLE.
- FSM states: IDLE, CLR_WR, CLR_ALL, DONE.
  - IDLE -> CLR_WR on clear_req.
  - CLR_WR / CLR_ALL: write 0 at address cnt; cnt increments by 1 per cycle; exit to DONE after cnt = DEPTH-1, i.e. exactly DEPTH cycles.
  - CLR_WR writes only the write bank. CLR_ALL writes both banks in the same cycle.
  - DONE: clear_done=1 for one cycle, cnt cleared, then -> IDLE.
- busy is high in CLR_WR, CLR_ALL and DONE, and is a registered function of state.
- Writes:
  - In IDLE with wr_en=1, mem[write bank][wr_addr] <= wr_data at the clock edge.
  - wr_en while busy is dropped silently.
  - wr_en and clear_req in the same IDLE cycle: clear wins and the write is dropped.
- Reads:
  - Without the read register, rd_data = mem[read bank][rd_addr] combinationally (0-cycle latency).
  - Reads are unaffected by a CLR_WR in progress.
  - During CLR_ALL, the read bank is also being zeroed and read data is undefined until clear_done.
- Swap:
  - In IDLE, swap toggles bank_sel at the clock edge.
  - A write in the same cycle as swap lands in the old write bank.
  - swap while busy sets swap_pending; bank_sel toggles on the DONE->IDLE edge and swap_pending clears.
  - Multiple swaps while busy collapse to one toggle.
- clear_req while busy is ignored, not queued.
- The clear counter is ADDR_BITS+1 wide or uses a terminal compare; no wrap-around aliasing is allowed.
- Reset mid-clear: the sweep aborts immediately. The clear restarts from address 0 only if CLEAR_ON_RESET=1.

Optional Feature:
- Macro: PINGPONG_COEF_RAM_RDREG_EN.
- Defined: rd_data comes from a register loaded every cycle with mem[read bank][rd_addr], giving 1-cycle read latency.
  - The register uses the bank_sel value of the sampling cycle.
  - The register resets to 0.
- Undefined: purely combinational read, 0-cycle latency, with no output register.

Test Plan:
- Auto-clear: CLEAR_ON_RESET=1; release rst_n -> busy=1 for exactly 2049 cycles (2048 CLR_ALL + 1 DONE); clear_done pulses once; reading addresses 0, 1023 and 2047 after swap returns 0 in both banks.
- Write/swap/read: write 0x11EE to addr 5 and 0x0001 to addr 2047 with bank_sel=0; pulse swap; bank_sel=1; read addr 5 -> 0x11EE and addr 2047 -> 0x0001 (one cycle later with RDREG_EN).
- Clear precedence: in IDLE, assert wr_en (addr 7, 0x0ABC) and clear_req together -> write dropped; after clear_done, swap and read addr 7 -> 0.
- Swap deferral: assert swap at cycle 100 of a CLR_WR sweep -> bank_sel unchanged until the DONE->IDLE edge, then toggles exactly once; two swaps while busy -> still one toggle.
- Write while busy: wr_en to addr 3 with 0x1234 during CLR_WR -> after completion and swap, addr 3 reads 0.
- Reset mid-clear: drop rst_n at sweep cycle 500 -> busy, clear_done and bank_sel go to 0 asynchronously; on release, with CLEAR_ON_RESET=1, the sweep restarts at address 0 and lasts a full 2048 cycles.
